// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: datapath width, NOP encoding and the
// {pc, instr} fetch packet handed from fetch to decode.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  // addi x0, x0, 0
  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_pkt_t;

endpackage

// File: rtl/fetch_decode_queue_if.sv
// Fetch/decode queue bus.
//   master : the fetch/decode side (drives in_valid/in_pc/in_instr, out_ready, flush)
//   slave  : the queue itself (drives in_ready, out_*, count, full, empty)
interface fetch_decode_queue_if #(
  parameter int unsigned XLEN  = riscv_pkg::XLEN,
  parameter int unsigned DEPTH = 4
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic             in_valid;
  logic             in_ready;
  logic [XLEN-1:0]  in_pc;
  logic [XLEN-1:0]  in_instr;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_pc;
  logic [XLEN-1:0]  out_instr;
  logic             flush;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;

  modport master (
    output in_valid, in_pc, in_instr, out_ready, flush,
    input  in_ready, out_valid, out_pc, out_instr, count, full, empty
  );

  modport slave (
    input  in_valid, in_pc, in_instr, out_ready, flush,
    output in_ready, out_valid, out_pc, out_instr, count, full, empty
  );

endinterface

// File: rtl/fetch_decode_queue_wrap_counter.sv
// Modulo-MAX pointer counter: 0 .. MAX-1 then back to 0, any MAX >= 2.
//   clock, reset : clock and async active-low reset
//   inc          : advance by one (wraps after MAX-1)
//   clr          : synchronous clear, wins over inc
//   value        : current count
module wrap_counter #(
  parameter int unsigned MAX = 4,
  localparam int unsigned W  = (MAX > 1) ? $clog2(MAX) : 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] value
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (inc) begin
      value <= (value == W'(MAX - 1)) ? '0 : value + W'(1);
    end
  end

endmodule

// File: rtl/fetch_decode_queue.sv
// Instruction buffer between fetch and decode. Holds up to DEPTH {pc, instr}
// packets and presents them in order; flush drops everything on a redirect.
//   clock, reset : clock and async active-low reset
//   bus (slave)  : in_* push side, out_* pop side, flush, count/full/empty
// No fall-through: out_* is a read of storage at rd_ptr, so a packet pushed
// in cycle N is visible from cycle N+1. A full queue refuses pushes even when
// a pop happens in the same cycle.
module fetch_decode_queue
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN  = riscv_pkg::XLEN,
  parameter int unsigned DEPTH = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  fetch_decode_queue_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned ENT_W = 2 * XLEN;

  logic [ENT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic             full_w;
  logic             empty_w;
  logic             push;
  logic             pop;
  logic [ENT_W-1:0] head;

  // Status and handshake qualification; flush suppresses both directions.
  always_comb begin
    full_w  = (count_q == CNT_W'(DEPTH));
    empty_w = (count_q == '0);
    push    = bus.in_valid && !full_w && !bus.flush;
    pop     = bus.out_ready && !empty_w && !bus.flush;
  end

  wrap_counter #(.MAX(DEPTH)) u_wr_ptr (
    .clock (clock),
    .reset (reset),
    .inc   (push),
    .clr   (bus.flush),
    .value (wr_ptr)
  );

  wrap_counter #(.MAX(DEPTH)) u_rd_ptr (
    .clock (clock),
    .reset (reset),
    .inc   (pop),
    .clr   (bus.flush),
    .value (rd_ptr)
  );

  // Occupancy: unchanged on simultaneous push and pop.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else if (bus.flush) begin
      count_q <= '0;
    end else if (push && !pop) begin
      count_q <= count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_q <= count_q - CNT_W'(1);
    end
  end

  // Storage is intentionally not reset; empty gates it off the outputs.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= {bus.in_pc, bus.in_instr};
    end
  end

  always_comb begin
    head          = mem[rd_ptr];
    bus.in_ready  = !full_w;
    bus.out_valid = !empty_w;
    bus.full      = full_w;
    bus.empty     = empty_w;
    bus.count     = count_q;
    bus.out_pc    = empty_w ? '0 : head[ENT_W-1:XLEN];
    bus.out_instr = empty_w ? '0 : head[XLEN-1:0];
  end

endmodule

// File: tb/tb_fetch_decode_queue.sv
module tb_fetch_decode_queue;
  import riscv_pkg::*;

  localparam int unsigned DA = 4;
  localparam int unsigned DB = 3;
  localparam logic [31:0] K  = 32'hA5A5_0000;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  fetch_decode_queue_if #(.XLEN(32), .DEPTH(DA)) ifa ();
  fetch_decode_queue_if #(.XLEN(32), .DEPTH(DB)) ifb ();

  fetch_decode_queue #(.XLEN(32), .DEPTH(DA)) u_a (.clock(clock), .reset(reset), .bus(ifa));
  fetch_decode_queue #(.XLEN(32), .DEPTH(DB)) u_b (.clock(clock), .reset(reset), .bus(ifb));

  int checks   = 0;
  int failures = 0;

  fetch_pkt_t qa[$];
  fetch_pkt_t qb[$];

  typedef struct {
    logic        iv;
    logic [31:0] pc;
    logic        ordy;
    logic        fl;
    int unsigned e_count;
    logic        e_ov;
    logic [31:0] e_pc;
  } vec_t;

  vec_t tbl[$];

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Reference: a bounded FIFO evaluated on the inputs present at the edge.
  task automatic model_a();
    bit do_push;
    bit do_pop;
    fetch_pkt_t p;
    if (ifa.flush) begin
      qa.delete();
    end else begin
      do_push = ifa.in_valid && (qa.size() < DA);
      do_pop  = ifa.out_ready && (qa.size() > 0);
      if (do_pop) p = qa.pop_front();
      if (do_push) qa.push_back('{pc: ifa.in_pc, instr: ifa.in_instr});
    end
  endtask

  task automatic model_b();
    bit do_push;
    bit do_pop;
    fetch_pkt_t p;
    if (ifb.flush) begin
      qb.delete();
    end else begin
      do_push = ifb.in_valid && (qb.size() < DB);
      do_pop  = ifb.out_ready && (qb.size() > 0);
      if (do_pop) p = qb.pop_front();
      if (do_push) qb.push_back('{pc: ifb.in_pc, instr: ifb.in_instr});
    end
  endtask

  task automatic tick();
    model_a();
    model_b();
    @(posedge clock);
    #1;
  endtask

  task automatic check_a(input string tag);
    logic [31:0] epc;
    logic [31:0] ein;
    epc = (qa.size() > 0) ? qa[0].pc    : 32'h0;
    ein = (qa.size() > 0) ? qa[0].instr : 32'h0;
    cmp({tag, ".count"},     64'(ifa.count),     64'(qa.size()));
    cmp({tag, ".full"},      64'(ifa.full),      64'(qa.size() == DA));
    cmp({tag, ".empty"},     64'(ifa.empty),     64'(qa.size() == 0));
    cmp({tag, ".in_ready"},  64'(ifa.in_ready),  64'(qa.size() != DA));
    cmp({tag, ".out_valid"}, 64'(ifa.out_valid), 64'(qa.size() != 0));
    cmp({tag, ".out_pc"},    64'(ifa.out_pc),    64'(epc));
    cmp({tag, ".out_instr"}, 64'(ifa.out_instr), 64'(ein));
  endtask

  task automatic check_b(input string tag);
    logic [31:0] epc;
    epc = (qb.size() > 0) ? qb[0].pc : 32'h0;
    cmp({tag, ".count"},  64'(ifb.count),  64'(qb.size()));
    cmp({tag, ".full"},   64'(ifb.full),   64'(qb.size() == DB));
    cmp({tag, ".empty"},  64'(ifb.empty),  64'(qb.size() == 0));
    cmp({tag, ".out_pc"}, 64'(ifb.out_pc), 64'(epc));
  endtask

  task automatic drive_a(input logic iv, input logic [31:0] pc, input logic [31:0] ins,
                         input logic ordy, input logic fl);
    ifa.in_valid  = iv;
    ifa.in_pc     = pc;
    ifa.in_instr  = ins;
    ifa.out_ready = ordy;
    ifa.flush     = fl;
  endtask

  task automatic add(input logic iv, input logic [31:0] pc, input logic ordy, input logic fl,
                     input int unsigned ec, input logic eov, input logic [31:0] epc);
    vec_t v;
    v.iv = iv; v.pc = pc; v.ordy = ordy; v.fl = fl;
    v.e_count = ec; v.e_ov = eov; v.e_pc = epc;
    tbl.push_back(v);
  endtask

  logic [31:0] sent[$];

  initial begin
    drive_a(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    ifb.in_valid = 1'b0; ifb.in_pc = '0; ifb.in_instr = '0;
    ifb.out_ready = 1'b0; ifb.flush = 1'b0;

    // Reset state while held in reset
    #12;
    cmp("rst.count",     64'(ifa.count),     64'd0);
    cmp("rst.empty",     64'(ifa.empty),     64'd1);
    cmp("rst.full",      64'(ifa.full),      64'd0);
    cmp("rst.in_ready",  64'(ifa.in_ready),  64'd1);
    cmp("rst.out_valid", 64'(ifa.out_valid), 64'd0);
    cmp("rst.out_pc",    64'(ifa.out_pc),    64'd0);
    @(posedge clock); #1;
    reset = 1'b1;

    // Fill, overflow hold, drain, then flush with a live push/pop
    add(1, 32'h0,   0, 0, 1, 1, 32'h0);
    add(1, 32'h4,   0, 0, 2, 1, 32'h0);
    add(1, 32'h8,   0, 0, 3, 1, 32'h0);
    add(1, 32'hC,   0, 0, 4, 1, 32'h0);
    add(1, 32'h10,  0, 0, 4, 1, 32'h0);
    add(1, 32'h10,  0, 0, 4, 1, 32'h0);
    add(1, 32'h10,  0, 0, 4, 1, 32'h0);
    add(1, 32'h10,  1, 0, 3, 1, 32'h4);
    add(1, 32'h10,  0, 0, 4, 1, 32'h4);
    add(0, 32'h0,   1, 0, 3, 1, 32'h8);
    add(0, 32'h0,   1, 0, 2, 1, 32'hC);
    add(0, 32'h0,   1, 0, 1, 1, 32'h10);
    add(0, 32'h0,   1, 0, 0, 0, 32'h0);
    add(0, 32'h0,   1, 0, 0, 0, 32'h0);
    add(1, 32'h100, 0, 0, 1, 1, 32'h100);
    add(1, 32'h104, 0, 0, 2, 1, 32'h100);
    add(1, 32'h108, 0, 0, 3, 1, 32'h100);
    add(1, 32'h10C, 1, 1, 0, 0, 32'h0);
    add(1, 32'h200, 0, 0, 1, 1, 32'h200);
    add(0, 32'h0,   1, 0, 0, 0, 32'h0);

    for (int i = 0; i < tbl.size(); i++) begin
      string t;
      t = $sformatf("vec%0d", i);
      drive_a(tbl[i].iv, tbl[i].pc, tbl[i].pc ^ K, tbl[i].ordy, tbl[i].fl);
      tick();
      cmp({t, ".count"},     64'(ifa.count),     64'(tbl[i].e_count));
      cmp({t, ".out_valid"}, 64'(ifa.out_valid), 64'(tbl[i].e_ov));
      cmp({t, ".out_pc"},    64'(ifa.out_pc),    64'(tbl[i].e_pc));
      cmp({t, ".out_instr"}, 64'(ifa.out_instr), 64'(tbl[i].e_ov ? (tbl[i].e_pc ^ K) : 32'h0));
      cmp({t, ".full"},      64'(ifa.full),      64'(tbl[i].e_count == DA));
      cmp({t, ".in_ready"},  64'(ifa.in_ready),  64'(tbl[i].e_count != DA));
    end

    // Streaming at a steady occupancy of two
    for (int i = 0; i < 22; i++) sent.push_back($urandom);
    drive_a(1, 32'h300, sent[0], 0, 0); tick();
    drive_a(1, 32'h304, sent[1], 0, 0); tick();
    for (int k = 0; k < 20; k++) begin
      drive_a(1, 32'h308 + 32'(4 * k), sent[k + 2], 1, 0);
      tick();
      cmp($sformatf("stream%0d.count", k), 64'(ifa.count),     64'd2);
      cmp($sformatf("stream%0d.instr", k), 64'(ifa.out_instr), 64'(sent[k + 1]));
    end
    drive_a(0, 32'h0, 32'h0, 1, 0); tick(); tick();
    check_a("stream_end");

    // Randomised traffic against the reference queue
    for (int n = 0; n < 400; n++) begin
      drive_a(($urandom % 4) != 0, $urandom, $urandom, ($urandom % 2) == 0,
              ($urandom % 25) == 0);
      tick();
      check_a($sformatf("rnd%0d", n));
    end

    // Asynchronous reset with three entries queued
    drive_a(0, 32'h0, 32'h0, 0, 1); tick();
    for (int i = 0; i < 3; i++) begin
      drive_a(1, 32'h400 + 32'(4 * i), $urandom, 0, 0);
      tick();
    end
    drive_a(0, 32'h0, 32'h0, 0, 0);
    check_a("pre_arst");
    #2;
    reset = 1'b0;
    #1;
    qa.delete();
    qb.delete();
    cmp("arst.count",     64'(ifa.count),     64'd0);
    cmp("arst.empty",     64'(ifa.empty),     64'd1);
    cmp("arst.out_valid", 64'(ifa.out_valid), 64'd0);
    cmp("arst.in_ready",  64'(ifa.in_ready),  64'd1);
    cmp("arst.out_pc",    64'(ifa.out_pc),    64'd0);
    @(posedge clock); #1;
    reset = 1'b1;
    drive_a(1, 32'h500, 32'h1234_5678, 0, 0); tick();
    drive_a(0, 32'h0, 32'h0, 0, 0);
    check_a("post_arst");

    // Depth-3 instance: ten packets through a wrapping pointer pair
    begin
      int unsigned nxt;
      int unsigned pidx;
      int cyc;
      nxt  = 0;
      pidx = 0;
      cyc  = 0;
      while (pidx < 10 && cyc < 100) begin
        ifb.in_valid  = (nxt < 10);
        ifb.in_pc     = 32'(nxt * 4);
        ifb.in_instr  = $urandom;
        ifb.out_ready = (nxt >= 10) || (cyc >= 3 && (cyc % 2) == 1);
        ifb.flush     = 1'b0;
        if (ifb.out_ready && ifb.out_valid) begin
          cmp($sformatf("wrap.pop%0d", pidx), 64'(ifb.out_pc), 64'(pidx * 4));
          pidx++;
        end
        if (ifb.in_valid && qb.size() < DB) nxt++;
        tick();
        check_b($sformatf("wrap%0d", cyc));
        cyc++;
      end
      cmp("wrap.done", 64'(pidx), 64'd10);
      ifb.in_valid = 1'b0;
      ifb.out_ready = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
